// File: rtl/regfile_write_arbiter.sv
// Arbitrates the register file's single write port among NREQ valid/ready requesters and
// runs a clear sequence that zeroes x1..x31. Define ARB_FIXED_PRIO_EN for fixed priority.
module regfile_write_arbiter #(
    parameter int NREQ = 2,
    parameter int AW   = 5,
    parameter int DW   = 32
) (
    input  logic               CLK,
    input  logic               areset,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]    req_ready,
    input  logic               clr_req,
    output logic               clr_busy,
    output logic               clr_done,
    output logic               WE3,
    output logic [AW-1:0]      A3,
    output logic [DW-1:0]      WD3
);
    typedef enum logic {ARB, CLEAR} state_t;

    localparam logic [AW-1:0] LAST_ADDR = '1;

    state_t          state_q, state_d;
    logic [AW-1:0]   clr_cnt_q, clr_cnt_d;
    logic            we3_q, we3_d;
    logic [AW-1:0]   a3_q, a3_d;
    logic [DW-1:0]   wd3_q, wd3_d;
    logic            clr_busy_q, clr_busy_d;
    logic            clr_done_q, clr_done_d;

    logic [NREQ-1:0] pick;
    logic [NREQ-1:0] grant;
    logic [AW-1:0]   gnt_addr;
    logic [DW-1:0]   gnt_data;
    logic            arb_open;
    logic            hs;

`ifndef ARB_FIXED_PRIO_EN
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [PW-1:0]   gnt_idx;
    logic [NREQ-1:0] upper;

    // Requesters at or above the pointer get first chance; fall back to the rest.
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            upper[i] = req_valid[i] && (PW'(i) >= rr_ptr_q);
        end
        pick = (upper != '0) ? upper : req_valid;
    end
`else
    assign pick = req_valid;
`endif

    // Lowest set bit of pick wins.
    always_comb begin
        grant    = '0;
        gnt_addr = '0;
        gnt_data = '0;
`ifndef ARB_FIXED_PRIO_EN
        gnt_idx  = '0;
`endif
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (pick[i]) begin
                grant    = '0;
                grant[i] = 1'b1;
                gnt_addr = req_addr[i*AW +: AW];
                gnt_data = req_data[i*DW +: DW];
`ifndef ARB_FIXED_PRIO_EN
                gnt_idx  = PW'(i);
`endif
            end
        end
    end

    assign arb_open  = areset && (state_q == ARB) && !clr_req;
    assign req_ready = arb_open ? grant : '0;
    assign hs        = |(req_ready & req_valid);

`ifndef ARB_FIXED_PRIO_EN
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (hs) begin
            rr_ptr_d = (gnt_idx == PW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge areset) begin
        if (!areset) rr_ptr_q <= '0;
        else         rr_ptr_q <= rr_ptr_d;
    end
`endif

    always_comb begin
        state_d    = state_q;
        clr_cnt_d  = clr_cnt_q;
        we3_d      = 1'b0;
        a3_d       = a3_q;
        wd3_d      = wd3_q;
        clr_busy_d = 1'b0;
        clr_done_d = 1'b0;
        case (state_q)
            ARB: begin
                if (clr_req) begin
                    state_d    = CLEAR;
                    clr_cnt_d  = AW'(1);
                    we3_d      = 1'b1;
                    a3_d       = AW'(1);
                    wd3_d      = '0;
                    clr_busy_d = 1'b1;
                end else if (hs) begin
                    // x0 writes are accepted but never reach the register file.
                    we3_d = (gnt_addr != '0);
                    a3_d  = gnt_addr;
                    wd3_d = gnt_data;
                end
            end
            CLEAR: begin
                if (clr_cnt_q == LAST_ADDR) begin
                    state_d    = ARB;
                    clr_done_d = 1'b1;
                end else begin
                    clr_cnt_d  = clr_cnt_q + 1'b1;
                    we3_d      = 1'b1;
                    a3_d       = clr_cnt_q + 1'b1;
                    wd3_d      = '0;
                    clr_busy_d = 1'b1;
                end
            end
            default: state_d = ARB;
        endcase
    end

    always_ff @(posedge CLK or negedge areset) begin
        if (!areset) begin
            state_q    <= ARB;
            clr_cnt_q  <= '0;
            we3_q      <= 1'b0;
            a3_q       <= '0;
            wd3_q      <= '0;
            clr_busy_q <= 1'b0;
            clr_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_cnt_q  <= clr_cnt_d;
            we3_q      <= we3_d;
            a3_q       <= a3_d;
            wd3_q      <= wd3_d;
            clr_busy_q <= clr_busy_d;
            clr_done_q <= clr_done_d;
        end
    end

    assign WE3      = we3_q;
    assign A3       = a3_q;
    assign WD3      = wd3_q;
    assign clr_busy = clr_busy_q;
    assign clr_done = clr_done_q;
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter (NREQ=2); a small register array captures
// WE3/A3/WD3 to stand in for the register file.
module tb_regfile_write_arbiter;
    localparam int NREQ = 2;
    localparam int AW   = 5;
    localparam int DW   = 32;

    logic               CLK;
    logic               areset;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    req_ready;
    logic               clr_req;
    logic               clr_busy;
    logic               clr_done;
    logic               WE3;
    logic [AW-1:0]      A3;
    logic [DW-1:0]      WD3;

    logic [DW-1:0] rf [0:31];
    int checks = 0;
    int errors = 0;

    regfile_write_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
        .CLK(CLK), .areset(areset),
        .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
        .req_ready(req_ready),
        .clr_req(clr_req), .clr_busy(clr_busy), .clr_done(clr_done),
        .WE3(WE3), .A3(A3), .WD3(WD3)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        if (WE3) rf[A3] <= WD3;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_addr[i*AW +: AW] = a;
        req_data[i*DW +: DW] = d;
    endtask

    function automatic logic [DW-1:0] pv(input int k);
        return 32'hA500_0000 | DW'(k);
    endfunction

    // Writes x1..x31 with pv(k) through requester 1, leaving the pointer at 0.
    task automatic preload();
        for (int k = 1; k < 32; k++) begin
            req_valid = 2'b10;
            set_req(1, AW'(k), pv(k));
            next_cycle();
        end
        req_valid = 2'b00;
        next_cycle();
    endtask

    // A single x0 handshake by requester 0 moves the round-robin pointer to 1.
    task automatic bump_ptr();
        req_valid = 2'b01;
        set_req(0, '0, 32'h0);
        next_cycle();
        req_valid = 2'b00;
    endtask

    initial begin
        logic [1:0] exp_rdy;
        logic [AW-1:0] exp_a;
        int bad;

        for (int k = 0; k < 32; k++) rf[k] = '0;
        areset    = 1'b1;
        req_valid = 2'b11;
        req_addr  = '0;
        req_data  = '0;
        clr_req   = 1'b0;
        set_req(0, 5'd3, 32'h3333_3333);
        set_req(1, 5'd4, 32'h4444_4444);
        #2 areset = 1'b0;

        // Reset with both requesters valid
        next_cycle();
        next_cycle();
        check("rst_ready", req_ready, 2'b00);
        check("rst_we3", WE3, 1'b0);
        check("rst_a3", A3, 0);
        check("rst_wd3", WD3, 0);
        check("rst_busy", clr_busy, 1'b0);
        check("rst_done", clr_done, 1'b0);

        @(negedge CLK);
        areset    = 1'b1;
        req_valid = 2'b00;
        next_cycle();

        // Single request from requester 1
        req_valid = 2'b10;
        set_req(1, 5'd5, 32'hDEAD_BEEF);
        #1 check("single_ready", req_ready, 2'b10);
        next_cycle();
        req_valid = 2'b00;
        check("single_we3", WE3, 1'b1);
        check("single_a3", A3, 5);
        check("single_wd3", WD3, 32'hDEAD_BEEF);
        next_cycle();
        check("idle_we3", WE3, 1'b0);
        check("idle_a3_hold", A3, 5);
        check("rf_x5", rf[5], 32'hDEAD_BEEF);

        // Contention: both valid for four cycles
        set_req(0, 5'd3, 32'h3333_3333);
        set_req(1, 5'd4, 32'h4444_4444);
        req_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
`ifdef ARB_FIXED_PRIO_EN
            exp_rdy = 2'b01;
            exp_a   = 5'd3;
`else
            exp_rdy = (k % 2 == 0) ? 2'b01 : 2'b10;
            exp_a   = (k % 2 == 0) ? 5'd3 : 5'd4;
`endif
            #1 check("cont_ready", req_ready, exp_rdy);
            next_cycle();
            check("cont_we3", WE3, 1'b1);
            check("cont_a3", A3, exp_a);
        end
        req_valid = 2'b00;

        // x0 write is granted but suppressed
        req_valid = 2'b01;
        set_req(0, 5'd0, 32'h0000_1234);
        #1 check("x0_ready", req_ready, 2'b01);
        next_cycle();
        req_valid = 2'b00;
        check("x0_we3", WE3, 1'b0);
        next_cycle();
        check("rf_x0", rf[0], 0);

        // Clear sequence with requests pending
        preload();
        check("pre_x1", rf[1], pv(1));
        check("pre_x31", rf[31], pv(31));
        bump_ptr();
        set_req(0, 5'd7, 32'h77);
        set_req(1, 5'd9, 32'h99);
        req_valid = 2'b11;
        clr_req   = 1'b1;
        #1 check("clr_req_ready", req_ready, 2'b00);
        next_cycle();
        clr_req = 1'b0;
        for (int k = 1; k < 32; k++) begin
            check("clr_ready", req_ready, 2'b00);
            check("clr_we3", WE3, 1'b1);
            check("clr_a3", A3, k);
            check("clr_wd3", WD3, 0);
            check("clr_busy", clr_busy, 1'b1);
            check("clr_done_early", clr_done, 1'b0);
            next_cycle();
        end
        check("clr_done", clr_done, 1'b1);
        check("clr_busy_end", clr_busy, 1'b0);
        check("clr_we3_end", WE3, 1'b0);
`ifdef ARB_FIXED_PRIO_EN
        check("clr_pend_ready", req_ready, 2'b01);
`else
        check("clr_pend_ready", req_ready, 2'b10);
`endif
        bad = 0;
        for (int k = 1; k < 32; k++) if (rf[k] != '0) bad++;
        check("clr_rf_zero", bad, 0);
        next_cycle();
        req_valid = 2'b00;
        check("clr_done_pulse", clr_done, 1'b0);
        check("post_we3", WE3, 1'b1);
`ifdef ARB_FIXED_PRIO_EN
        check("post_a3", A3, 7);
        check("post_wd3", WD3, 32'h77);
`else
        check("post_a3", A3, 9);
        check("post_wd3", WD3, 32'h99);
`endif
        next_cycle();

        // Reset in the middle of a clear
        preload();
        bump_ptr();
        clr_req = 1'b1;
        next_cycle();
        clr_req = 1'b0;
        for (int k = 1; k < 10; k++) next_cycle();
        check("abort_a3_pre", A3, 10);
        req_valid = 2'b11;
        set_req(0, 5'd2, 32'h22);
        areset = 1'b0;
        #1;
        check("abort_we3", WE3, 1'b0);
        check("abort_a3", A3, 0);
        check("abort_wd3", WD3, 0);
        check("abort_busy", clr_busy, 1'b0);
        check("abort_ready", req_ready, 2'b00);
        @(negedge CLK);
        bad = 0;
        for (int k = 1; k < 10; k++) if (rf[k] != '0) bad++;
        check("abort_low_zero", bad, 0);
        bad = 0;
        for (int k = 10; k < 32; k++) if (rf[k] != pv(k)) bad++;
        check("abort_high_kept", bad, 0);
        areset = 1'b1;
        #1 check("abort_arb_ready", req_ready, 2'b01);
        next_cycle();
        req_valid = 2'b00;
        check("abort_arb_we3", WE3, 1'b1);
        check("abort_arb_a3", A3, 2);
        check("abort_arb_busy", clr_busy, 1'b0);
        next_cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
